// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: FSM state codes, flag bit positions
// and a saturating increment used by the optional statistics counters.
package alu_issue_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t ACTIVE = 2'd1;
   localparam state_t FLUSH  = 2'd2;

   localparam int OVF   = 2;
   localparam int ZERO  = 1;
   localparam int CARRY = 0;

   localparam int LATENCY_MAX = 8;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request and response handshake bundle between a requester/consumer (master)
// and the ALU issue controller (slave).
interface alu_issue_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [2:0]       req_op;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic [2:0]       rsp_flags;
   logic [TAG_W-1:0] rsp_tag;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
   );
endinterface

// File: rtl/alu_issue_ctrl_rsp_fifo.sv
// Synchronous first-word-fall-through FIFO holding ALU responses; the head is
// presented combinationally and reads as zero while empty.
module alu_rsp_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     dout,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      empty    = (count_q == '0);
      full     = (count_q == CNT_W'(DEPTH));
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign dout  = empty ? '0 : mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/alu_issue_ctrl.sv
// Credit-based issue controller for the registered ALU datapath.
// Define ALU_ISSUE_STATS_EN to add the stat_issued / stat_ovf saturating counters.
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int LATENCY   = 1,
   parameter int RSP_DEPTH = 4,
   parameter int TAG_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   alu_issue_ctrl_if.slave  bus,
   input  logic             flush,
   output logic [WIDTH-1:0] alu_r2,
   output logic [WIDTH-1:0] alu_r3,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_r0,
   input  logic             alu_overflow,
   input  logic             alu_zero,
   input  logic             alu_carry,
   output logic             busy
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [31:0]      stat_issued,
   output logic [31:0]      stat_ovf
`endif
);
   localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
   localparam int PIPE_N = LATENCY + 1;
   localparam int ENT_W  = WIDTH + 3 + TAG_W;

   state_t           state_q, state_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [PIPE_N-1:0] vld_q, vld_d;
   logic [TAG_W-1:0] ptag_q [PIPE_N];
   logic [TAG_W-1:0] ptag_d [PIPE_N];
   logic [WIDTH-1:0] r2_q, r2_d, r3_q, r3_d;
   logic [2:0]       op_q, op_d;

   logic [CNT_W-1:0] inflight, fifo_count, used, credits;
   logic             req_ready, accept, push, pop;
   logic             fifo_empty, fifo_full;
   logic [2:0]       cap_flags;
   logic [ENT_W-1:0] push_data, head_data;

   // Stage 0 of the valid pipe lines up with the alu_* registers and the last
   // stage with the registered alu_r0, so the last stage marks a result to capture.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < PIPE_N; i++) begin
         inflight = inflight + CNT_W'(vld_q[i]);
      end
      used             = inflight + fifo_count;
      credits          = CNT_W'(RSP_DEPTH) - used;
      req_ready        = (state_q != FLUSH) && (credits != '0);
      accept           = bus.req_valid && req_ready && !flush;
      pop              = !fifo_empty && bus.rsp_ready;
      push             = vld_q[PIPE_N-1];
      cap_flags        = '0;
      cap_flags[OVF]   = alu_overflow;
      cap_flags[ZERO]  = alu_zero;
      cap_flags[CARRY] = alu_carry;
      push_data        = {alu_r0, cap_flags, ptag_q[PIPE_N-1]};
   end

   always_comb begin
      r2_d      = r2_q;
      r3_d      = r3_q;
      op_d      = op_q;
      tag_d     = tag_q;
      vld_d     = {vld_q[PIPE_N-2:0], accept};
      ptag_d[0] = tag_q;
      for (int i = 1; i < PIPE_N; i++) begin
         ptag_d[i] = ptag_q[i-1];
      end
      if (accept) begin
         r2_d  = bus.req_a;
         r3_d  = bus.req_b;
         op_d  = bus.req_op;
         tag_d = tag_q + 1'b1;
      end

      state_d = state_q;
      if (flush) begin
         state_d = FLUSH;
      end else begin
         case (state_q)
            IDLE:    if (accept) state_d = ACTIVE;
            ACTIVE:  if (used == '0 && !accept) state_d = IDLE;
            FLUSH:   if (used == '0) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tag_q   <= '0;
         vld_q   <= '0;
         r2_q    <= '0;
         r3_q    <= '0;
         op_q    <= '0;
         for (int i = 0; i < PIPE_N; i++) begin
            ptag_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         vld_q   <= vld_d;
         r2_q    <= r2_d;
         r3_q    <= r3_d;
         op_q    <= op_d;
         ptag_q  <= ptag_d;
      end
   end

   alu_rsp_fifo #(
      .W     (ENT_W),
      .DEPTH (RSP_DEPTH),
      .CNT_W (CNT_W)
   ) u_rsp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (push_data),
      .dout  (head_data),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   // Credits make both of these impossible; they guard the accounting.
   always @(posedge clk) begin
      if (!rst) begin
         assert (used <= CNT_W'(RSP_DEPTH));
         assert (!(push && fifo_full && !pop));
      end
   end

`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] stat_issued_q, stat_issued_d, stat_ovf_q, stat_ovf_d;

   always_comb begin
      stat_issued_d = stat_issued_q;
      stat_ovf_d    = stat_ovf_q;
      if (accept) begin
         stat_issued_d = sat_inc(stat_issued_q);
      end
      if (push && alu_overflow) begin
         stat_ovf_d = sat_inc(stat_ovf_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issued_q <= '0;
         stat_ovf_q    <= '0;
      end else begin
         stat_issued_q <= stat_issued_d;
         stat_ovf_q    <= stat_ovf_d;
      end
   end

   assign stat_issued = stat_issued_q;
   assign stat_ovf    = stat_ovf_q;
`endif

   assign alu_r2        = r2_q;
   assign alu_r3        = r3_q;
   assign alu_op        = op_q;
   assign busy          = (state_q != IDLE);
   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = !fifo_empty;
   assign {bus.rsp_result, bus.rsp_flags, bus.rsp_tag} = head_data;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an adder stub as the ALU and a response scoreboard.
module tb_alu_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [31:0] alu_r2, alu_r3, alu_r0;
   logic [2:0]  alu_op;
   logic        alu_overflow, alu_zero, alu_carry;
   logic        busy;
`ifdef ALU_ISSUE_STATS_EN
   logic [31:0] stat_issued, stat_ovf;
`endif

   int          checks = 0;
   int          errors = 0;
   int          pop_count = 0;
   int          accepted;
   int          pops_before;
   logic [3:0]  last_tag = '0;
   logic [3:0]  model_tag = '0;
   logic [38:0] exp_q[$];

   alu_issue_ctrl_if #(.WIDTH(32), .TAG_W(4)) m ();

   alu_issue_ctrl #(
      .WIDTH(32), .LATENCY(1), .RSP_DEPTH(4), .TAG_W(4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (m),
      .flush        (flush),
      .alu_r2       (alu_r2),
      .alu_r3       (alu_r3),
      .alu_op       (alu_op),
      .alu_r0       (alu_r0),
      .alu_overflow (alu_overflow),
      .alu_zero     (alu_zero),
      .alu_carry    (alu_carry),
      .busy         (busy)
`ifdef ALU_ISSUE_STATS_EN
      ,
      .stat_issued  (stat_issued),
      .stat_ovf     (stat_ovf)
`endif
   );

   always #5 clk = ~clk;

   // Returns {sum, overflow, zero, carry} of a 32-bit addition.
   function automatic logic [34:0] aluModel(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return {s[31:0], (a[31] == b[31]) && (s[31] != a[31]), s[31:0] == 32'd0, s[32]};
   endfunction

   always @(posedge clk) begin
      {alu_r0, alu_overflow, alu_zero, alu_carry} <= aluModel(alu_r2, alu_r3);
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("[TB] check %s did not hold", tag);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                                input logic [2:0] op);
      m.req_valid = v;
      m.req_a     = a;
      m.req_b     = b;
      m.req_op    = op;
   endtask

   task automatic waitRsp(input int maxc, input string tag);
      for (int i = 0; i < maxc && !m.rsp_valid; i++) tick();
      checkOutput(tag, 64'(m.rsp_valid), 64'd1);
   endtask

   task automatic waitIdle(input int maxc, input string tag);
      for (int i = 0; i < maxc && (busy || exp_q.size() != 0); i++) tick();
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_sb_left"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard: accepts push expectations, pops compare against the FIFO head.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         model_tag = '0;
      end else begin
         if (m.rsp_valid && m.rsp_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("sb_unexpected_rsp", 64'(exp_q.size()), 64'd1);
            end else begin
               checkOutput("sb_rsp", 64'({m.rsp_result, m.rsp_flags, m.rsp_tag}),
                           64'(exp_q.pop_front()));
               pop_count++;
               last_tag = m.rsp_tag;
            end
         end
         if (m.req_valid && m.req_ready && !flush) begin
            exp_q.push_back({aluModel(m.req_a, m.req_b), model_tag});
            model_tag++;
         end
      end
   end

   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      applyStimulus(1'b0, '0, '0, '0);
      m.rsp_ready = 1'b1;
      tick(2);
      rst = 1'b0;
      #1;
      checkOutput("reset_req_ready", 64'(m.req_ready), 64'd1);
      checkOutput("reset_rsp_valid", 64'(m.rsp_valid), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_alu", 64'({alu_r2, alu_op}), 64'd0);
      checkOutput("reset_rsp_data", 64'({m.rsp_result, m.rsp_flags, m.rsp_tag}), 64'd0);

      $display("[TB] single operation");
      applyStimulus(1'b1, 32'd5, 32'd7, 3'd3);
      checkOutput("single_ready", 64'(m.req_ready), 64'd1);
      tick();
      applyStimulus(1'b0, '0, '0, '0);
      checkOutput("single_r2", 64'(alu_r2), 64'd5);
      checkOutput("single_r3", 64'(alu_r3), 64'd7);
      checkOutput("single_op", 64'(alu_op), 64'd3);
      checkOutput("single_busy", 64'(busy), 64'd1);
      checkOutput("single_early", 64'(m.rsp_valid), 64'd0);
      tick();
      checkOutput("single_early2", 64'(m.rsp_valid), 64'd0);
      tick();
      checkOutput("single_valid", 64'(m.rsp_valid), 64'd1);
      checkOutput("single_result", 64'(m.rsp_result), 64'd12);
      checkOutput("single_flags", 64'(m.rsp_flags), 64'd0);
      checkOutput("single_tag", 64'(m.rsp_tag), 64'd0);
      waitIdle(20, "single");

      $display("[TB] credit stall");
      m.rsp_ready = 1'b0;
      accepted = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 32'(100 + i), 32'(200 + i), 3'(i));
         if (m.req_ready) accepted++;
         tick();
      end
      checkOutput("stall_accepts", 64'(accepted), 64'd4);
      checkOutput("stall_ready", 64'(m.req_ready), 64'd0);
      m.rsp_ready = 1'b1;
      tick();
      m.rsp_ready = 1'b0;
      checkOutput("credit_freed", 64'(m.req_ready), 64'd1);
      tick();
      checkOutput("credit_used", 64'(m.req_ready), 64'd0);
      applyStimulus(1'b0, '0, '0, '0);
      m.rsp_ready = 1'b1;
      waitIdle(40, "stall");

      $display("[TB] flags");
      applyStimulus(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd0);
      tick();
      applyStimulus(1'b0, '0, '0, '0);
      waitRsp(10, "flags_zc_rsp");
      checkOutput("flags_zc_result", 64'(m.rsp_result), 64'd0);
      checkOutput("flags_zc", 64'(m.rsp_flags), 64'b011);
      tick();
      applyStimulus(1'b1, 32'h7FFF_FFFF, 32'd1, 3'd0);
      tick();
      applyStimulus(1'b0, '0, '0, '0);
      waitRsp(10, "flags_ovf_rsp");
      checkOutput("flags_ovf_result", 64'(m.rsp_result), 64'h8000_0000);
      checkOutput("flags_ovf", 64'(m.rsp_flags), 64'b100);
      waitIdle(20, "flags");

      $display("[TB] tag wrap");
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      pops_before = pop_count;
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 32'(i * 3), 32'(i + 1), 3'(i));
         tick();
      end
      applyStimulus(1'b0, '0, '0, '0);
      waitIdle(40, "wrap");
      checkOutput("wrap_count", 64'(pop_count - pops_before), 64'd17);
      checkOutput("wrap_last_tag", 64'(last_tag), 64'd0);

      $display("[TB] flush");
      m.rsp_ready = 1'b0;
      applyStimulus(1'b1, 32'd10, 32'd20, 3'd1);
      tick();
      applyStimulus(1'b1, 32'd11, 32'd21, 3'd2);
      tick();
      applyStimulus(1'b1, 32'd12, 32'd22, 3'd3);
      tick();
      flush = 1'b1;
      checkOutput("flush_pre_ready", 64'(m.req_ready), 64'd1);
      tick();
      flush = 1'b0;
      checkOutput("flush_blocks", 64'(m.req_ready), 64'd0);
      checkOutput("flush_busy", 64'(busy), 64'd1);
      tick(3);
      checkOutput("flush_hold", 64'(m.req_ready), 64'd0);
      m.rsp_ready = 1'b1;
      for (int i = 0; i < 20 && busy; i++) begin
         checkOutput("flush_ready_low", 64'(m.req_ready), 64'd0);
         tick();
      end
      checkOutput("flush_idle", 64'(busy), 64'd0);
      checkOutput("flush_drained", 64'(exp_q.size()), 64'd0);
      checkOutput("flush_resume_ready", 64'(m.req_ready), 64'd1);
      tick();
      applyStimulus(1'b0, '0, '0, '0);
      waitIdle(20, "flush_after");

      $display("[TB] async reset mid-burst");
      m.rsp_ready = 1'b0;
      applyStimulus(1'b1, 32'd1, 32'd2, 3'd0);
      tick();
      applyStimulus(1'b1, 32'd3, 32'd4, 3'd0);
      tick();
      applyStimulus(1'b0, '0, '0, '0);
      tick();
      checkOutput("pre_rst_valid", 64'(m.rsp_valid), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_rsp_valid", 64'(m.rsp_valid), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_req_ready", 64'(m.req_ready), 64'd1);
      tick(2);
      rst = 1'b0;
      m.rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("post_rst_no_rsp", 64'(m.rsp_valid), 64'd0);
      end
      checkOutput("post_rst_ready", 64'(m.req_ready), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
